// File: rtl/sc_tty_pkg.sv
// Shared constants and FSM encoding for the MCU TTY transmitter.
// The optional parity stage is enabled with the SC_TTY_PARITY_EN macro.
package sc_tty_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tty_state_e;

    localparam int TTY_CLK_DIV = 434;
    localparam int TTY_DATA_W  = 8;

endpackage

// File: rtl/sc_fifo_sync.sv
// Single-clock FIFO with fill level; power-of-two depth.
// A push while full is accepted only when a pop happens on the same edge.
module sc_fifo_sync
    import sc_tty_pkg::*;
#(
    parameter int  DEPTH = 16,
    parameter int  W     = TTY_DATA_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  wdata_i,
    output logic [W-1:0]  rdata_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          wr, rd;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    assign wr = push_i && (!full_o || pop_i);
    assign rd = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wr ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = rd ? rptr_q + 1'b1 : rptr_q;
        level_d = level_q;
        if (wr && !rd) level_d = level_q + 1'b1;
        if (rd && !wr) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sc_tty_tx.sv
// TTY window responder: buffers bus byte writes and sends them as UART.
// Define SC_TTY_PARITY_EN to add an even-parity bit before the stop bit.
module sc_tty_tx
    import sc_tty_pkg::*;
#(
    parameter int  CLK_DIV    = TTY_CLK_DIV,
    parameter int  FIFO_DEPTH = 16,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1,
    localparam int BW         = $clog2(CLK_DIV)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          tty_we_i,
    input  logic [31:0]   tty_data_i,
    output logic          tx_o,
    output logic          busy_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [LW-1:0] level_o,
    output logic          overflow_o
);

    tty_state_e                state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [TTY_DATA_W-1:0]     data_q, data_d;
    logic                      tx_q, tx_d;
    logic                      ovf_q, ovf_d;
    logic                      pop, push_ok, baud_end;
    logic                      fifo_full, fifo_empty;
    logic [TTY_DATA_W-1:0]     fifo_rdata;
    logic                      unused_hi;

    assign unused_hi = ^tty_data_i[31:TTY_DATA_W];

    assign push_ok = tty_we_i && (!fifo_full || pop);
    assign ovf_d   = ovf_q | (tty_we_i & ~push_ok);

    sc_fifo_sync #(
        .DEPTH (FIFO_DEPTH),
        .W     (TTY_DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i (tty_data_i[TTY_DATA_W-1:0]),
        .rdata_o (fifo_rdata),
        .level_o (level_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign baud_end = (baud_q == BW'(CLK_DIV - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_rdata;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
`ifdef SC_TTY_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef SC_TTY_PARITY_EN
            ST_PARITY: begin
                if (baud_end) state_d = ST_STOP;
            end
`endif
            // Next byte starts right after the stop bit, no idle gap.
            ST_STOP: begin
                if (baud_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_rdata;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = data_d[bit_d];
`ifdef SC_TTY_PARITY_EN
            ST_PARITY: tx_d = ^data_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx_o       = tx_q;
    assign busy_o     = (state_q != ST_IDLE) | ~fifo_empty;
    assign empty_o    = fifo_empty;
    assign full_o     = fifo_full;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_sc_tty_tx.sv
// Directed bench for sc_tty_tx with CLK_DIV=4, FIFO_DEPTH=4.
// Build with SC_TTY_PARITY_EN defined to exercise the parity frame.
module tb_sc_tty_tx;

    localparam int DIV = 4;
`ifdef SC_TTY_PARITY_EN
    localparam int FRAME = 11 * DIV;
`else
    localparam int FRAME = 10 * DIV;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [31:0] data;
    logic        tx, busy, empty, full, ovf;
    logic [2:0]  level;

    int n_chk  = 0;
    int n_fail = 0;

    sc_tty_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .tty_we_i   (we),
        .tty_data_i (data),
        .tx_o       (tx),
        .busy_o     (busy),
        .empty_o    (empty),
        .full_o     (full),
        .level_o    (level),
        .overflow_o (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample i is taken 1 time unit after the i-th edge following the
    // edge at which the frame's start bit was launched.
    task automatic check_frame(input logic [7:0] b, input int first);
        for (int i = first; i < FRAME; i++) begin
            int   slot;
            logic e;
            slot = i / DIV;
            if (slot == 0)      e = 1'b0;
            else if (slot <= 8) e = b[slot-1];
`ifdef SC_TTY_PARITY_EN
            else if (slot == 9) e = ^b;
`endif
            else                e = 1'b1;
            chk($sformatf("frame_%02h_s%0d", b, i), tx, e);
            tick();
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int lows;
        rst_n = 1'b0;
        we    = 1'b0;
        data  = '0;
        #1;

        // 1: reset state and quiet idle line
        do_reset(3);
        chk("rst_tx", tx, 1);
        chk("rst_empty", empty, 1);
        chk("rst_busy", busy, 0);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("idle_quiet", lows, 0);

        // 2: single byte 0x41 (upper data bits ignored)
        we = 1'b1; data = 32'h0000_0141;
        tick();
        we = 1'b0; data = '0;
        chk("t2_lat_hi", tx, 1);
        chk("t2_level", level, 1);
        chk("t2_busy_q", busy, 1);
        tick();
        chk("t2_busy", busy, 1);
        chk("t2_popped", empty, 1);
        check_frame(8'h41, 0);
        chk("t2_end_tx", tx, 1);
        chk("t2_end_busy", busy, 0);

        // 3: three consecutive writes, back-to-back frames
        we = 1'b1; data = 32'hDEAD_BE55;
        tick();
        data = 32'h1234_56AA;
        tick();
        chk("t3_start", tx, 0);
        data = 32'hFFFF_FF0F;
        tick();
        we = 1'b0; data = '0;
        chk("t3_level", level, 2);
        check_frame(8'h55, 1);
        check_frame(8'hAA, 0);
        check_frame(8'h0F, 0);
        chk("t3_end_tx", tx, 1);
        chk("t3_end_busy", busy, 0);
        chk("t3_ovf", ovf, 0);

        // 4: six writes into a 4-deep FIFO, sixth is dropped
        for (int k = 0; k < 6; k++) begin
            we = 1'b1; data = 32'h11 + k;
            tick();
            if (k >= 1 && k <= 4) chk($sformatf("t4_start_%0d", k), tx, 0);
            chk($sformatf("t4_level_%0d", k), level,
                (k == 0) ? 1 : (k >= 4) ? 4 : k);
            chk($sformatf("t4_full_%0d", k), full, (k >= 4) ? 1 : 0);
            chk($sformatf("t4_ovf_%0d", k), ovf, (k == 5) ? 1 : 0);
        end
        we = 1'b0; data = '0;
        check_frame(8'h11, 4);
        for (int k = 1; k < 5; k++) check_frame(8'h11 + k, 0);
        chk("t4_end_tx", tx, 1);
        chk("t4_end_busy", busy, 0);
        chk("t4_end_level", level, 0);
        chk("t4_ovf_sticky", ovf, 1);
        repeat (20) tick();
        chk("t4_ovf_hold", ovf, 1);
        chk("t4_no_sixth", tx, 1);

        // 5: reset during data bit 3 with two bytes queued
        do_reset(1);
        chk("t5_ovf_clr", ovf, 0);
        we = 1'b1; data = 32'hA5;
        tick();
        data = 32'h3C;
        tick();
        data = 32'h99;
        tick();
        we = 1'b0; data = '0;
        repeat (16) tick();
        chk("t5_bit3", tx, 0);
        chk("t5_queued", level, 2);
        rst_n = 1'b0;
        tick();
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_level", level, 0);
        chk("t5_rst_empty", empty, 1);
        chk("t5_rst_busy", busy, 0);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        chk("t5_no_frames", lows, 0);
        chk("t5_idle_busy", busy, 0);

`ifdef SC_TTY_PARITY_EN
        // 6: parity frames, even parity of 0x41 is 0 and of 0x07 is 1
        we = 1'b1; data = 32'h41;
        tick();
        we = 1'b0; data = '0;
        tick();
        check_frame(8'h41, 0);
        chk("t6_end41", busy, 0);
        we = 1'b1; data = 32'h07;
        tick();
        we = 1'b0; data = '0;
        tick();
        check_frame(8'h07, 0);
        chk("t6_end07", busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
